// File: rtl/cmos_pixel_pack.sv
// DVP pixel packer: gathers RATIO sensor beats into one output word, with line-end
// padding, frame-start/line-end markers, start-up frame skip and line/frame size counters.
module cmos_pixel_pack #(
  parameter int unsigned IN_W        = 8,
  parameter int unsigned RATIO       = 2,
  parameter int unsigned BYTE_ORDER  = 0,
  parameter int unsigned PAD_PARTIAL = 1,
  parameter int unsigned SKIP_FRAMES = 0,
  parameter int unsigned CNT_W       = 12
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic [IN_W-1:0]       pdata_i,
  output logic                  de_o,
  output logic [IN_W*RATIO-1:0] pdata_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  partial_o,
  output logic [CNT_W-1:0]      line_words_o,
  output logic [CNT_W-1:0]      frame_lines_o
);

  localparam int unsigned OutW  = IN_W * RATIO;
  localparam int unsigned BcW   = $clog2(RATIO);
  localparam int unsigned SkipW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  logic             vs_dly_q, de_dly_q;
  logic             synced_q, sof_pend_q;
  logic [SkipW-1:0] skip_q;
  logic [BcW-1:0]   bc_q;
  logic [OutW-1:0]  acc_q;
  logic [CNT_W-1:0] word_cnt_q, line_cnt_q;
  logic             de_o_q, sof_o_q, eol_o_q, partial_o_q;
  logic [OutW-1:0]  pdata_o_q;
  logic [CNT_W-1:0] line_words_q, frame_lines_q;

  logic             vs_rise, beat, line_end, suppress, last_beat, pad_emit, emit, show;
  logic [OutW-1:0]  acc_ins, word;
  logic [CNT_W-1:0] word_cnt_nx, line_cnt_inc;

  always_comb begin
    vs_rise   = vs_i & ~vs_dly_q;
    beat      = synced_q & de_i & ~vs_i;
    line_end  = synced_q & de_dly_q & ~de_i & ~vs_i;
    suppress  = (skip_q != '0);
    last_beat = beat & (bc_q == BcW'(RATIO - 1));
    pad_emit  = line_end & (bc_q != '0) & (PAD_PARTIAL != 0);
    emit      = last_beat | pad_emit;
    show      = emit & ~suppress;

    acc_ins = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (bc_q == BcW'(k)) begin
        if (BYTE_ORDER != 0) acc_ins[k*IN_W +: IN_W] = pdata_i;
        else                 acc_ins[OutW - (k+1)*IN_W +: IN_W] = pdata_i;
      end
    end
    // Unfilled slots of a padded word are already zero: acc_q clears on every wrap.
    word = last_beat ? acc_ins : acc_q;

    word_cnt_nx = word_cnt_q;
    if (emit && (word_cnt_q != '1)) word_cnt_nx = word_cnt_q + 1'b1;
    line_cnt_inc = (line_cnt_q != '1) ? line_cnt_q + 1'b1 : line_cnt_q;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly_q      <= 1'b0;
      de_dly_q      <= 1'b0;
      synced_q      <= 1'b0;
      sof_pend_q    <= 1'b0;
      skip_q        <= '0;
      bc_q          <= '0;
      acc_q         <= '0;
      word_cnt_q    <= '0;
      line_cnt_q    <= '0;
      de_o_q        <= 1'b0;
      sof_o_q       <= 1'b0;
      eol_o_q       <= 1'b0;
      partial_o_q   <= 1'b0;
      pdata_o_q     <= '0;
      line_words_q  <= '0;
      frame_lines_q <= '0;
    end else begin
      vs_dly_q    <= vs_i;
      // Qualified with vs_i so a line cut short by vsync never looks like a line end.
      de_dly_q    <= de_i & ~vs_i;
      de_o_q      <= show;
      sof_o_q     <= show & sof_pend_q;
      eol_o_q     <= line_end & ~suppress;
      partial_o_q <= line_end & (bc_q != '0) & ~suppress;

      if (show) begin
        pdata_o_q  <= word;
        sof_pend_q <= 1'b0;
      end

      if (vs_rise) begin
        synced_q      <= 1'b1;
        sof_pend_q    <= 1'b1;
        frame_lines_q <= line_cnt_q;
        line_cnt_q    <= '0;
        if (!synced_q)          skip_q <= SkipW'(SKIP_FRAMES);
        else if (skip_q != '0) skip_q <= skip_q - 1'b1;
      end

      if (vs_i) begin
        bc_q       <= '0;
        acc_q      <= '0;
        word_cnt_q <= '0;
      end else if (line_end) begin
        bc_q         <= '0;
        acc_q        <= '0;
        word_cnt_q   <= '0;
        line_words_q <= word_cnt_nx;
        line_cnt_q   <= line_cnt_inc;
      end else if (beat) begin
        word_cnt_q <= word_cnt_nx;
        if (last_beat) begin
          bc_q  <= '0;
          acc_q <= '0;
        end else begin
          bc_q  <= bc_q + 1'b1;
          acc_q <= acc_ins;
        end
      end
    end
  end

  assign de_o          = de_o_q;
  assign pdata_o       = pdata_o_q;
  assign sof_o         = sof_o_q;
  assign eol_o         = eol_o_q;
  assign partial_o     = partial_o_q;
  assign line_words_o  = line_words_q;
  assign frame_lines_o = frame_lines_q;

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Bench for cmos_pixel_pack: four parameter variants share one DVP stream; an event-level
// reference model predicts every output pulse, plus a directed table for the default build.
module tb_cmos_pixel_pack;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs_i = 1'b0;
  logic       de_i = 1'b0;
  logic [7:0] pdata_i = 8'h00;

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // d0: 8->16 MSB-first pad; d1: 8->32 LSB-first; d2: no pad; d3: skip 2 frames
  logic [3:0]  deo, sofo, eolo, parto;
  logic [15:0] pd0, pd2, pd3;
  logic [31:0] pd1;
  logic [11:0] lw [4];
  logic [11:0] fl [4];

  cmos_pixel_pack #(.RATIO(2), .BYTE_ORDER(0), .PAD_PARTIAL(1), .SKIP_FRAMES(0)) u_d0 (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
    .de_o(deo[0]), .pdata_o(pd0), .sof_o(sofo[0]), .eol_o(eolo[0]), .partial_o(parto[0]),
    .line_words_o(lw[0]), .frame_lines_o(fl[0]));
  cmos_pixel_pack #(.RATIO(4), .BYTE_ORDER(1), .PAD_PARTIAL(1), .SKIP_FRAMES(0)) u_d1 (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
    .de_o(deo[1]), .pdata_o(pd1), .sof_o(sofo[1]), .eol_o(eolo[1]), .partial_o(parto[1]),
    .line_words_o(lw[1]), .frame_lines_o(fl[1]));
  cmos_pixel_pack #(.RATIO(2), .BYTE_ORDER(0), .PAD_PARTIAL(0), .SKIP_FRAMES(0)) u_d2 (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
    .de_o(deo[2]), .pdata_o(pd2), .sof_o(sofo[2]), .eol_o(eolo[2]), .partial_o(parto[2]),
    .line_words_o(lw[2]), .frame_lines_o(fl[2]));
  cmos_pixel_pack #(.RATIO(2), .BYTE_ORDER(0), .PAD_PARTIAL(1), .SKIP_FRAMES(2)) u_d3 (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
    .de_o(deo[3]), .pdata_o(pd3), .sof_o(sofo[3]), .eol_o(eolo[3]), .partial_o(parto[3]),
    .line_words_o(lw[3]), .frame_lines_o(fl[3]));

  function automatic int cfg_ratio(int d); return (d == 1) ? 4 : 2; endfunction
  function automatic bit cfg_bo(int d);    return (d == 1);         endfunction
  function automatic bit cfg_pad(int d);   return (d != 2);         endfunction
  function automatic int cfg_skip(int d);  return (d == 3) ? 2 : 0; endfunction

  function automatic logic [31:0] pdw(int d);
    case (d)
      0:       return {16'h0, pd0};
      1:       return pd1;
      2:       return {16'h0, pd2};
      default: return {16'h0, pd3};
    endcase
  endfunction

  // kind: 0 word, 1 line end, 2 frame_lines sample, 3 partial without line end
  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] data;
    logic        sof;
    logic        part;
    logic [11:0] cnt;
  } ev_t;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    int          n;
    logic [7:0]  b [6];
    int          nw;
    logic [15:0] w [3];
    logic        part;
    logic [11:0] lw;
    logic [31:0] w1;
  } vec_t;

  ev_t  exp_q [4][$];
  ev_t  obs_q [4][$];
  vec_t tbl [3];
  int   checks = 0;
  int   passed = 0;

  function automatic ev_t mk_ev(int c, int k, logic [31:0] data, logic sof, logic part,
                                logic [11:0] cnt);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = data; e.sof = sof; e.part = part; e.cnt = cnt;
    return e;
  endfunction

  function automatic string ev_str(ev_t e);
    return $sformatf("cyc=%0d kind=%0d data=%0h sof=%0b part=%0b cnt=%0d",
                     e.cyc, e.kind, e.data, e.sof, e.part, e.cnt);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // ---------------- reference model (works on whole lines and frame boundaries) ----------
  int m_synced [4];
  int m_skip   [4];
  int m_sofp   [4];
  int m_lines  [4];

  function automatic logic [31:0] pack(int d, bq_t b, int first, int cnt);
    logic [31:0] w = 32'h0;
    int r = cfg_ratio(d);
    for (int k = 0; k < cnt; k++) begin
      if (cfg_bo(d)) w |= 32'(b[first+k]) << (8 * k);
      else           w |= 32'(b[first+k]) << (8 * (r - 1 - k));
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_synced[d] = 0; m_skip[d] = 0; m_sofp[d] = 0; m_lines[d] = 0;
    end
  endtask

  task automatic model_vs_rise(int v);
    for (int d = 0; d < 4; d++) begin
      exp_q[d].push_back(mk_ev(v, 2, 32'h0, 1'b0, 1'b0, 12'(m_lines[d])));
      m_lines[d] = 0;
      if (m_synced[d] == 0) begin
        m_synced[d] = 1;
        m_skip[d]   = cfg_skip(d);
      end else if (m_skip[d] > 0) begin
        m_skip[d]--;
      end
      m_sofp[d] = 1;
    end
  endtask

  // Line whose first beat is sampled at edge s; abort means vsync cut it short.
  task automatic model_line(bq_t b, int s, bit abort);
    for (int d = 0; d < 4; d++) begin
      int r = cfg_ratio(d);
      int n = b.size();
      int nw = 0;
      int rem = n % r;
      bit sup = (m_skip[d] > 0);
      if (m_synced[d] == 0) continue;
      for (int j = 0; (j + 1) * r <= n; j++) begin
        nw++;
        if (!sup) begin
          exp_q[d].push_back(mk_ev(s + (j+1)*r - 1, 0, pack(d, b, j*r, r), 1'(m_sofp[d]),
                                   1'b0, 12'h0));
          m_sofp[d] = 0;
        end
      end
      if (abort) continue;
      if (rem != 0 && cfg_pad(d)) begin
        nw++;
        if (!sup) begin
          exp_q[d].push_back(mk_ev(s + n, 0, pack(d, b, n - rem, rem), 1'(m_sofp[d]),
                                   1'b0, 12'h0));
          m_sofp[d] = 0;
        end
      end
      if (!sup)
        exp_q[d].push_back(mk_ev(s + n, 1, 32'h0, 1'b0, rem != 0, 12'((nw > 4095) ? 4095 : nw)));
      if (m_lines[d] < 4095) m_lines[d]++;
    end
  endtask

  // ---------------- monitor ----------------
  logic vs_s = 1'b0, vs_s2 = 1'b0;
  always @(posedge pclk) begin
    vs_s  <= vs_i;
    vs_s2 <= vs_s;
  end

  always @(negedge pclk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        if (deo[d] || sofo[d])
          obs_q[d].push_back(mk_ev(cyc, 0, pdw(d), sofo[d], 1'b0, 12'h0));
        if (eolo[d])
          obs_q[d].push_back(mk_ev(cyc, 1, 32'h0, 1'b0, parto[d], lw[d]));
        else if (parto[d])
          obs_q[d].push_back(mk_ev(cyc, 3, 32'h0, 1'b0, 1'b1, 12'h0));
        if (vs_s && !vs_s2)
          obs_q[d].push_back(mk_ev(cyc, 2, 32'h0, 1'b0, 1'b0, fl[d]));
      end
    end
  end

  task automatic flush(string tag);
    repeat (4) @(negedge pclk);
    #1;
    for (int d = 0; d < 4; d++) begin
      int n = (exp_q[d].size() > obs_q[d].size()) ? exp_q[d].size() : obs_q[d].size();
      for (int i = 0; i < n; i++) begin
        bit ha = (i < obs_q[d].size());
        bit hr = (i < exp_q[d].size());
        checks++;
        if (ha && hr && obs_q[d][i] == exp_q[d][i]) passed++;
        else $display("FAIL %s d%0d ev%0d: got {%s} expected {%s}", tag, d, i,
                      ha ? ev_str(obs_q[d][i]) : "none", hr ? ev_str(exp_q[d][i]) : "none");
      end
      exp_q[d].delete();
      obs_q[d].delete();
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(int n);
    repeat (n) begin
      @(negedge pclk);
      de_i = 1'b0; vs_i = 1'b0; pdata_i = 8'($urandom);
    end
  endtask

  task automatic vs_pulse(int hi, bit de_hold);
    @(negedge pclk);
    vs_i = 1'b1; de_i = de_hold; pdata_i = 8'($urandom);
    model_vs_rise(cyc + 1);
    repeat (hi - 1) begin
      @(negedge pclk);
      de_i = 1'($urandom); pdata_i = 8'($urandom);
    end
    @(negedge pclk);
    vs_i = 1'b0; de_i = 1'b0;
  endtask

  task automatic send_line(bq_t b, bit abort);
    int s = 0;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge pclk);
      if (i == 0) s = cyc + 1;
      de_i = 1'b1; pdata_i = b[i];
    end
    if (abort) begin
      model_line(b, s, 1'b1);
      vs_pulse(3, 1'b1);
    end else begin
      @(negedge pclk);
      de_i = 1'b0; pdata_i = 8'($urandom);
      model_line(b, s, 1'b0);
    end
  endtask

  function automatic bq_t rand_line(int n);
    bq_t q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic check_reset(string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_flags_d%0d", tag, d), {60'h0, deo[d], sofo[d], eolo[d], parto[d]}, 0);
      check($sformatf("%s_pdata_d%0d", tag, d), pdw(d), 0);
      check($sformatf("%s_counts_d%0d", tag, d), {lw[d], fl[d]}, 0);
    end
  endtask

  initial begin
    tbl[0] = '{n: 4, b: '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00}, nw: 2,
               w: '{16'hA1B2, 16'hC3D4, 16'h0000}, part: 1'b0, lw: 12'd2, w1: 32'hD4C3B2A1};
    tbl[1] = '{n: 5, b: '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00}, nw: 3,
               w: '{16'h1122, 16'h3344, 16'h5500}, part: 1'b1, lw: 12'd3, w1: 32'h44332211};
    tbl[2] = '{n: 1, b: '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nw: 1,
               w: '{16'h7E00, 16'h0000, 16'h0000}, part: 1'b1, lw: 12'd1, w1: 32'h0000007E};
    model_reset();

    repeat (3) @(negedge pclk);
    check_reset("reset");
    @(negedge pclk);
    #2 rst_n = 1'b1;

    // Data before the first vsync is discarded.
    send_line(rand_line(6), 1'b0);
    idle(2);
    flush("presync");

    // Frame 1: directed table for the default build (and the 32-bit LSB-first build).
    vs_pulse(2, 1'b0);
    idle(2);
    for (int t = 0; t < 3; t++) begin
      bq_t q;
      int m0, m1, nw;
      logic [11:0] got_lw;
      logic got_part, got_w1;
      q = {};
      for (int i = 0; i < tbl[t].n; i++) q.push_back(tbl[t].b[i]);
      m0 = obs_q[0].size();
      m1 = obs_q[1].size();
      send_line(q, 1'b0);
      idle(2);
      #1;
      nw = 0; got_lw = 12'hFFF; got_part = 1'bx; got_w1 = 1'b0;
      for (int i = m0; i < obs_q[0].size(); i++) begin
        if (obs_q[0][i].kind == 0) begin
          if (nw < 3) check($sformatf("tbl%0d_word%0d", t, nw), obs_q[0][i].data, tbl[t].w[nw]);
          nw++;
        end else if (obs_q[0][i].kind == 1) begin
          got_lw = obs_q[0][i].cnt;
          got_part = obs_q[0][i].part;
        end
      end
      check($sformatf("tbl%0d_nwords", t), nw, tbl[t].nw);
      check($sformatf("tbl%0d_line_words", t), got_lw, tbl[t].lw);
      check($sformatf("tbl%0d_partial", t), got_part, tbl[t].part);
      for (int i = m1; i < obs_q[1].size(); i++) begin
        if (obs_q[1][i].kind == 0 && !got_w1) begin
          check($sformatf("tbl%0d_r4_word", t), obs_q[1][i].data, tbl[t].w1);
          got_w1 = 1'b1;
        end
      end
      check($sformatf("tbl%0d_r4_seen", t), got_w1, 1'b1);
    end
    flush("table");

    // Frame 2 (still skipped on d3), then frame 3 with a vsync cutting a line after 3 beats.
    vs_pulse(2, 1'b0);
    send_line(rand_line(7), 1'b0);
    send_line(rand_line(4), 1'b0);
    flush("frame2");
    vs_pulse(1, 1'b0);
    send_line(rand_line(6), 1'b0);
    send_line(rand_line(3), 1'b1);
    idle(1);
    send_line(rand_line(4), 1'b0);
    idle(2);
    flush("abort");

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      vs_pulse(1 + $urandom_range(2), 1'b0);
      idle($urandom_range(2));
      for (int l = 0; l < 1 + $urandom_range(3); l++) begin
        send_line(rand_line(1 + $urandom_range(8)), ($urandom_range(7) == 0));
        idle($urandom_range(2));
      end
      flush($sformatf("rand%0d", f));
    end

    // Asynchronous reset in the middle of a word.
    vs_pulse(2, 1'b0);
    begin
      bq_t q;
      int s;
      q = rand_line(3);
      s = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge pclk);
        if (i == 0) s = cyc + 1;
        de_i = 1'b1; pdata_i = q[i];
      end
      @(posedge pclk);
      #1 rst_n = 1'b0;
      model_line(q, s, 1'b1);
      model_reset();
      de_i = 1'b0;
      #2 check_reset("midreset");
      @(negedge pclk);
      #2 rst_n = 1'b1;
    end
    flush("midreset");
    send_line(rand_line(5), 1'b0);
    idle(2);
    flush("postreset_presync");
    for (int f = 0; f < 4; f++) begin
      vs_pulse(2, 1'b0);
      send_line(rand_line(1 + $urandom_range(8)), 1'b0);
      send_line(rand_line(1 + $urandom_range(8)), 1'b0);
      flush($sformatf("postreset%0d", f));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
